// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx serializer among NUM_REQ byte requesters with round-robin
// arbitration. The granted byte is latched, the serializer start is pulsed, and
// the busy flag is tracked through completion. An optional idle gap follows each
// byte. If busy never rises after a start, a timeout pulse is raised.
// Optional feature macro: UART_TX_ARBITER_LOCK_EN
//   When defined, the last grantee is re-granted ahead of round-robin while it
//   holds both i_lock and i_req, which keeps a multi-byte frame contiguous.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_req_byte,
    input  logic [NUM_REQ-1:0]         i_lock,
    output logic [NUM_REQ-1:0]         o_req_ack,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                       o_active,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_busy,
    output logic                       o_err_timeout
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (GAP_CLKS > BUSY_TIMEOUT) ? GAP_CLKS : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal count values for the shared counter.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_idx_nxt;
    logic [7:0]         r_tx_byte;
    logic [7:0]         w_tx_byte_nxt;
    logic [NUM_REQ-1:0] r_req_ack;
    logic [NUM_REQ-1:0] w_req_ack_nxt;
    logic               r_tx_start;
    logic               w_tx_start_nxt;
    logic               r_err_timeout;
    logic               w_err_timeout_nxt;
    logic               r_active;
    logic               w_sel_vld;
    logic [IDX_W-1:0]   w_sel_idx;

`ifdef UART_TX_ARBITER_LOCK_EN
    // Set by every grant, cleared by a timeout so the next pick is plain round-robin.
    logic               r_lock_ok;
    logic               w_lock_ok_nxt;
`else
    logic               w_unused_lock;
    assign w_unused_lock = ^i_lock;
`endif

    // (base + off) modulo NUM_REQ, for off in 0..NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum + 0;
        end
        return IDX_W'(sum);
    endfunction

    // Select the requester to serve: locked re-grant first (when built in), else first set bit from rr upward.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
`ifdef UART_TX_ARBITER_LOCK_EN
        if (r_lock_ok && i_lock[r_grant_idx] && i_req[r_grant_idx]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = r_grant_idx;
        end else begin
            w_sel_vld = 1'b0;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_sel_vld && i_req[rr_wrap(r_rr, i)]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = rr_wrap(r_rr, i);
            end else begin
                w_sel_idx = w_sel_idx;
            end
        end
    end

    // Next-state and next-output logic for the grant / start / busy-tracking sequence.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_rr_nxt          = r_rr;
        w_grant_idx_nxt   = r_grant_idx;
        w_tx_byte_nxt     = r_tx_byte;
        w_req_ack_nxt     = '0;
        w_tx_start_nxt    = 1'b0;
        w_err_timeout_nxt = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
        w_lock_ok_nxt     = r_lock_ok;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_tx_byte_nxt   = i_req_byte[{w_sel_idx, 3'b000} +: 8];
                    w_grant_idx_nxt = w_sel_idx;
                    w_req_ack_nxt   = ACK_ONE << w_sel_idx;
                    w_tx_start_nxt  = 1'b1;
                    w_rr_nxt        = rr_wrap(w_sel_idx, 1);
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_WAIT_BUSY;
`ifdef UART_TX_ARBITER_LOCK_EN
                    w_lock_ok_nxt   = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == TO_LAST) begin
                    // Serializer never acknowledged: drop the byte, rr stays advanced.
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_IDLE;
`ifdef UART_TX_ARBITER_LOCK_EN
                    w_lock_ok_nxt     = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (GAP_CLKS > 0) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rr          <= '0;
            r_grant_idx   <= '0;
            r_tx_byte     <= 8'h00;
            r_req_ack     <= '0;
            r_tx_start    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_active      <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
            r_lock_ok     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rr          <= w_rr_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_req_ack     <= w_req_ack_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_active      <= (w_state_nxt != ST_IDLE);
`ifdef UART_TX_ARBITER_LOCK_EN
            r_lock_ok     <= w_lock_ok_nxt;
`endif
        end
    end

    assign o_req_ack     = r_req_ack;
    assign o_grant_idx   = r_grant_idx;
    assign o_active      = r_active;
    assign o_tx_start    = r_tx_start;
    assign o_tx_byte     = r_tx_byte;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: randomized requesters and a serializer model,
// checked against a byte-level arbitration model; a second instance with a gap.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int GAP = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req, lock, ack;
    logic [8*N-1:0] req_byte;
    logic [1:0]     gidx;
    logic           active, start, busy, err;
    logic [7:0]     txb;

    logic [N-1:0]   g_req, g_ack;
    logic [8*N-1:0] g_byte;
    logic [1:0]     g_gidx;
    logic           g_active, g_start, g_busy, g_err;
    logic [7:0]     g_txb;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(0), .BUSY_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_byte(req_byte), .i_lock(lock),
        .o_req_ack(ack), .o_grant_idx(gidx), .o_active(active), .o_tx_start(start),
        .o_tx_byte(txb), .i_tx_busy(busy), .o_err_timeout(err));

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP), .BUSY_TIMEOUT(TO)) dut_gap (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(g_req), .i_req_byte(g_byte), .i_lock(4'b0000),
        .o_req_ack(g_ack), .o_grant_idx(g_gidx), .o_active(g_active), .o_tx_start(g_start),
        .o_tx_byte(g_txb), .i_tx_busy(g_busy), .o_err_timeout(g_err));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Batch description for the main instance.
    int         b_cnt  [N];
    int         b_next [N];
    logic [7:0] b_bytes[N][4];
    logic [N-1:0] b_lock;
    int         drive_cyc;

    // Serializer model controls and observation logs.
    bit ser_en;
    int ser_dly, ser_len, ser_wait, ser_run;
    int ack_idx_q[$], ack_cyc_q[$], gidx_q[$], start_cyc_q[$], err_cyc_q[$];
    logic [7:0] tx_q[$];
    int ack_bad, fall_cyc, act_fall_cyc;
    logic prev_active, err_active;

    // Reference model state (byte level).
    int m_rr, m_last;
    bit m_lock_ok;
    int exp_seq[$];
    logic [7:0] exp_tx[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters, serializer and event logging, all acting on the falling edge.
    always @(negedge clk) begin
        if (ack !== '0) begin
            if ($countones(ack) != 1) ack_bad++;
            for (int k = 0; k < N; k++) begin
                if (ack[k]) begin
                    ack_idx_q.push_back(k);
                    ack_cyc_q.push_back(cyc);
                    gidx_q.push_back(int'(gidx));
                    b_next[k]++;
                    if (b_next[k] < b_cnt[k]) req_byte[8*k +: 8] = b_bytes[k][b_next[k]];
                    else begin req[k] = 1'b0; lock[k] = 1'b0; end
                end
            end
        end
        if (err === 1'b1) begin err_cyc_q.push_back(cyc); err_active = active; end
        if (prev_active === 1'b1 && active === 1'b0) act_fall_cyc = cyc;
        prev_active = active;
        if (start === 1'b1) begin
            tx_q.push_back(txb);
            start_cyc_q.push_back(cyc);
            if (ser_en) ser_wait = ser_dly;
        end else if (ser_wait > 0) begin
            ser_wait--;
            if (ser_wait == 0) begin busy = 1'b1; ser_run = ser_len; end
        end else if (ser_run > 0) begin
            ser_run--;
            if (ser_run == 0) begin busy = 1'b0; fall_cyc = cyc + 1; end
        end
    end

    task automatic clear_logs();
        ack_idx_q.delete(); ack_cyc_q.delete(); gidx_q.delete();
        start_cyc_q.delete(); err_cyc_q.delete(); tx_q.delete();
        ack_bad = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; req = '0; lock = '0; busy = 1'b0; ser_wait = 0; ser_run = 0;
        g_req = '0; g_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        m_rr = 0; m_last = 0; m_lock_ok = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (req == '0 && active == 1'b0 && busy == 1'b0 && ser_wait == 0 && ser_run == 0) ok = 1'b1;
        end
    endtask

    // Drive one batch (b_cnt/b_bytes/b_lock) and compare against the model.
    task automatic run_batch(input string name);
        int cnt[N];
        int used[N];
        int tot, best;
        bit ok;
        clear_logs();
        exp_seq.delete(); exp_tx.delete();
        tot = 0;
        for (int k = 0; k < N; k++) begin cnt[k] = b_cnt[k]; used[k] = 0; tot += cnt[k]; end
        while (tot > 0) begin
            best = -1;
`ifdef UART_TX_ARBITER_LOCK_EN
            if (m_lock_ok && b_lock[m_last] && cnt[m_last] > 0) best = m_last;
`endif
            for (int d = 0; d < N; d++)
                if (best < 0 && cnt[(m_rr + d) % N] > 0) best = (m_rr + d) % N;
            exp_seq.push_back(best);
            exp_tx.push_back(b_bytes[best][used[best]]);
            used[best]++; cnt[best]--; tot--;
            m_rr = (best + 1) % N; m_last = best; m_lock_ok = 1'b1;
        end
        @(negedge clk); #1;
        drive_cyc = cyc;
        for (int k = 0; k < N; k++) begin
            b_next[k] = 0;
            if (b_cnt[k] > 0) begin
                req_byte[8*k +: 8] = b_bytes[k][0];
                req[k] = 1'b1; lock[k] = b_lock[k];
            end else begin
                req[k] = 1'b0; lock[k] = 1'b0;
            end
        end
        wait_idle(400, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s idle: not reached within 400 cycles", name); end
        n_cmp++;
        if (ack_idx_q.size() != exp_seq.size()) begin
            n_err++; $display("FAIL %s ack_count: got %0d want %0d", name, ack_idx_q.size(), exp_seq.size());
        end
        for (int i = 0; i < exp_seq.size() && i < ack_idx_q.size(); i++) begin
            n_cmp++;
            if (ack_idx_q[i] != exp_seq[i] || gidx_q[i] != exp_seq[i]) begin
                n_err++; $display("FAIL %s grant[%0d]: ack %0d idx %0d want %0d", name, i, ack_idx_q[i], gidx_q[i], exp_seq[i]);
            end
            n_cmp++;
            if (i >= tx_q.size() || tx_q[i] !== exp_tx[i] || start_cyc_q[i] != ack_cyc_q[i]) begin
                n_err++; $display("FAIL %s tx[%0d]: got %h want %h", name, i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_tx[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (ack_cyc_q[i] <= ack_cyc_q[i-1]) begin
                    n_err++; $display("FAIL %s ack_spacing[%0d]: cycle %0d after %0d", name, i, ack_cyc_q[i], ack_cyc_q[i-1]);
                end
            end
        end
        n_cmp++;
        if (ack_bad != 0) begin n_err++; $display("FAIL %s onehot: %0d multi-bit acks want 0", name, ack_bad); end
        if (exp_tx.size() > 0) begin
            n_cmp++;
            if (txb !== exp_tx[exp_tx.size()-1]) begin
                n_err++; $display("FAIL %s tx_hold: got %h want %h", name, txb, exp_tx[exp_tx.size()-1]);
            end
        end
    endtask

    task automatic set_batch(input int c0, input int c1, input int c2, input int c3, input logic [N-1:0] lk);
        b_cnt[0] = c0; b_cnt[1] = c1; b_cnt[2] = c2; b_cnt[3] = c3; b_lock = lk;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++) b_bytes[k][j] = 8'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ack !== 4'b0000 || gidx !== 2'd0 || active !== 1'b0 || start !== 1'b0 || txb !== 8'h00 || err !== 1'b0) begin
            n_err++; $display("FAIL reset_main: ack %b idx %0d act %b start %b byte %h err %b want all 0", ack, gidx, active, start, txb, err);
        end
        n_cmp++;
        if (g_ack !== 4'b0000 || g_gidx !== 2'd0 || g_active !== 1'b0 || g_start !== 1'b0 || g_txb !== 8'h00 || g_err !== 1'b0) begin
            n_err++; $display("FAIL reset_gap: ack %b idx %0d act %b start %b byte %h err %b want all 0", g_ack, g_gidx, g_active, g_start, g_txb, g_err);
        end
    endtask

    task automatic test_single();
        ser_dly = 2; ser_len = 10;
        set_batch(0, 0, 1, 0, 4'b0000);
        b_bytes[2][0] = 8'hAB;
        run_batch("single");
        n_cmp++;
        if (ack_cyc_q.size() < 1 || ack_cyc_q[0] != drive_cyc + 1) begin
            n_err++; $display("FAIL single_latency: ack cycle %0d want %0d", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, drive_cyc + 1);
        end
        n_cmp++;
        if (gidx !== 2'd2 || txb !== 8'hAB) begin
            n_err++; $display("FAIL single_out: idx %0d byte %h want 2 ab", gidx, txb);
        end
        n_cmp++;
        if (act_fall_cyc != fall_cyc) begin
            n_err++; $display("FAIL single_active_fall: cycle %0d want %0d", act_fall_cyc, fall_cyc);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        ser_dly = $urandom_range(1, 3); ser_len = $urandom_range(1, 6);
        set_batch(1, 1, 1, 1, 4'b0000);
        b_bytes[0][0] = 8'h10; b_bytes[1][0] = 8'h21; b_bytes[2][0] = 8'h32; b_bytes[3][0] = 8'h43;
        run_batch("all_four");
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ack_idx_q.size() != 4 || ack_idx_q[i] != i) begin
                n_err++; $display("FAIL all_four_order[%0d]: got %0d want %0d", i, (ack_idx_q.size() > i) ? ack_idx_q[i] : -1, i);
            end
        end
    endtask

    task automatic test_rr_fair();
        set_batch(0, 0, 1, 0, 4'b0000);
        run_batch("rr_pre");
        set_batch(1, 0, 1, 0, 4'b0000);
        run_batch("rr_fair");
        n_cmp++;
        if (ack_idx_q.size() != 2 || ack_idx_q[0] != 0 || ack_idx_q[1] != 2) begin
            n_err++; $display("FAIL rr_fair_order: got %0d,%0d want 0,2",
                (ack_idx_q.size() > 0) ? ack_idx_q[0] : -1, (ack_idx_q.size() > 1) ? ack_idx_q[1] : -1);
        end
    endtask

    task automatic test_timeout();
        bit got;
        clear_logs();
        ser_en = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < N; k++) begin b_cnt[k] = 0; b_next[k] = 0; end
        b_cnt[1] = 1;
        req_byte[15:8] = 8'h77; lock[1] = 1'b1; req = 4'b0010;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            if (err_cyc_q.size() > 0) got = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (err_cyc_q.size() != 1 || start_cyc_q.size() != 1) begin
            n_err++; $display("FAIL timeout_count: errs %0d starts %0d want 1 1", err_cyc_q.size(), start_cyc_q.size());
        end else begin
            n_cmp++;
            if (err_cyc_q[0] - start_cyc_q[0] != TO) begin
                n_err++; $display("FAIL timeout_delay: got %0d want %0d", err_cyc_q[0] - start_cyc_q[0], TO);
            end
            n_cmp++;
            if (err_active !== 1'b0 || tx_q[0] !== 8'h77) begin
                n_err++; $display("FAIL timeout_state: active %b byte %h want 0 77", err_active, tx_q[0]);
            end
        end
        m_rr = 2; m_last = 1; m_lock_ok = 1'b0;
        ser_en = 1'b1; ser_dly = 2; ser_len = 3;
        set_batch(0, 1, 1, 0, 4'b0010);
        run_batch("after_timeout");
        n_cmp++;
        if (ack_idx_q.size() < 1 || ack_idx_q[0] != 2) begin
            n_err++; $display("FAIL timeout_next_grant: got %0d want 2", (ack_idx_q.size() > 0) ? ack_idx_q[0] : -1);
        end
    endtask

    task automatic test_lock();
        int want[5];
`ifdef UART_TX_ARBITER_LOCK_EN
        want = '{0, 0, 0, 1, 1};
`else
        want = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        set_batch(3, 2, 0, 0, 4'b0001);
        run_batch("lock");
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ack_idx_q.size() != 5 || ack_idx_q[i] != want[i]) begin
                n_err++; $display("FAIL lock_order[%0d]: got %0d want %0d", i, (ack_idx_q.size() > i) ? ack_idx_q[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            ser_dly = $urandom_range(1, 3); ser_len = $urandom_range(1, 6);
            set_batch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
            if (b_cnt[0] + b_cnt[1] + b_cnt[2] + b_cnt[3] == 0) b_cnt[$urandom_range(0, 3)] = 1;
            run_batch("random");
        end
    endtask

    task automatic wait_g_start(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            if (g_start === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_gap();
        int gf;
        bit got;
        do_reset();
        @(negedge clk); #1;
        g_byte = '0; g_byte[7:0] = 8'h5A; g_byte[15:8] = 8'hC3; g_req = 4'b0011;
        wait_g_start(10, got);
        n_cmp++;
        if (!got || g_ack !== 4'b0001 || g_txb !== 8'h5A) begin
            n_err++; $display("FAIL gap_first: start %b ack %b byte %h want 1 0001 5a", got, g_ack, g_txb);
        end
        g_req = 4'b0010;
        repeat (2) @(negedge clk);
        #1 g_busy = 1'b1;
        repeat (4) @(negedge clk);
        #1 g_busy = 1'b0; gf = cyc + 1;
        wait_g_start(20, got);
        n_cmp++;
        if (!got || cyc - gf != GAP + 1) begin
            n_err++; $display("FAIL gap_spacing: got %0d clocks want %0d", got ? cyc - gf : -1, GAP + 1);
        end
        n_cmp++;
        if (g_ack !== 4'b0010 || g_txb !== 8'hC3 || g_gidx !== 2'd1) begin
            n_err++; $display("FAIL gap_second: ack %b byte %h idx %0d want 0010 c3 1", g_ack, g_txb, g_gidx);
        end
        g_req = 4'b0000;
        repeat (2) @(negedge clk);
        #1 g_busy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (g_active !== 1'b1) begin n_err++; $display("FAIL gap_wait_done: active %b want 1", g_active); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (g_ack !== 4'b0000 || g_gidx !== 2'd0 || g_active !== 1'b0 || g_start !== 1'b0 || g_txb !== 8'h00 || g_err !== 1'b0) begin
            n_err++; $display("FAIL gap_midreset: ack %b idx %0d act %b start %b byte %h err %b want all 0", g_ack, g_gidx, g_active, g_start, g_txb, g_err);
        end
        rst_n = 1'b1; g_busy = 1'b0;
        m_rr = 0; m_last = 0; m_lock_ok = 1'b0;
        @(negedge clk); #1;
        g_byte[15:8] = 8'h66; g_byte[23:16] = 8'h99; g_req = 4'b0110;
        wait_g_start(10, got);
        n_cmp++;
        if (!got || g_gidx !== 2'd1 || g_txb !== 8'h66) begin
            n_err++; $display("FAIL gap_rr_after_reset: start %b idx %0d byte %h want 1 1 66", got, g_gidx, g_txb);
        end
        g_req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; req_byte = '0; busy = 1'b0;
        g_req = '0; g_byte = '0; g_busy = 1'b0;
        ser_en = 1'b1; ser_dly = 2; ser_len = 3; ser_wait = 0; ser_run = 0;
        fall_cyc = -1; act_fall_cyc = -2; prev_active = 1'b0; err_active = 1'b0;
        for (int k = 0; k < N; k++) begin b_cnt[k] = 0; b_next[k] = 0; end
        test_reset();
        test_single();
        test_all_four();
        test_rr_fair();
        test_timeout();
        test_lock();
        test_random();
        test_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer among NUM_REQ byte requesters using round-robin arbitration. It latches the granted requester's byte, pulses the serializer start, and tracks the serializer busy flag through completion. An optional inter-byte gap follows each byte. A busy-rise timeout detects a stuck or missing serializer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CLKS, 0, idle clocks inserted after busy falls, before the next grant (0 = no gap)
BUSY_TIMEOUT, 16, clocks to wait for i_tx_busy to rise after start before aborting

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous active-low reset
i_req  input  NUM_REQ  per-requester byte-valid, level
i_req_byte  input  8*NUM_REQ  requester k's byte on bits [8k+7:8k]
i_lock  input  NUM_REQ  per-requester grant-hold request (used only with the macro)
o_req_ack  output  NUM_REQ  one-hot, one-cycle pulse: byte taken from requester k
o_grant_idx  output  clog2(NUM_REQ)  index of the last granted requester
o_active  output  1  high in any state other than IDLE
o_tx_start  output  1  one-cycle start pulse to the serializer (drives its i_tx_byte_rdy)
o_tx_byte  output  8  latched byte to the serializer
i_tx_busy  input  1  serializer busy flag
o_err_timeout  output  1  one-cycle pulse when the busy-rise timeout expires

Behaviour:
- Reset values (i_rst_n low at a posedge): state=IDLE, rr pointer=0, all outputs 0. Reset mid-operation aborts immediately. The in-flight byte is not re-queued; the serializer is not told.
- Registers: count of width clog2(max(GAP_CLKS,BUSY_TIMEOUT)+1). rr pointer of width clog2(NUM_REQ), wraps NUM_REQ-1 -> 0.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any i_req bit is set, grant the first set bit searching from rr upward with wrap.
  - At that edge (1-cycle latency from request sampled): o_tx_byte <= selected byte, o_grant_idx <= k, o_req_ack[k]=1, o_tx_start=1 (both for one cycle), rr <= (k+1) mod NUM_REQ, count <= 0, state -> WAIT_BUSY.
- WAIT_BUSY:
  - i_tx_busy=1 -> WAIT_DONE.
  - Otherwise count++. When count reaches BUSY_TIMEOUT-1 without busy: o_err_timeout=1 for one cycle, state -> IDLE. The byte is dropped and rr stays advanced.
- WAIT_DONE:
  - i_tx_busy=0 -> GAP if GAP_CLKS>0 (count <= 0), else IDLE.
- GAP:
  - Count to GAP_CLKS-1, then -> IDLE.
  - No grant occurs in GAP, so the minimum idle between bytes is GAP_CLKS+1 clocks.
- Handshake rules:
  - A requester holds i_req and i_req_byte stable until o_req_ack.
  - A req dropped before ack has no effect.
  - A req still high the cycle after ack is a new byte and is arbitrated in the next IDLE.
- o_tx_byte stays stable from grant until the next grant.
- o_tx_start never asserts outside the IDLE->WAIT_BUSY transition.
- Requests arriving outside IDLE wait; nothing is lost because requesters hold.
- Simultaneous requests: exactly one ack per byte cycle. No requester waits more than NUM_REQ-1 grants.

Optional Feature:
Macro UART_TX_ARBITER_LOCK_EN.
- Defined: in IDLE, if i_lock[o_grant_idx] and i_req[o_grant_idx] are both high, the last grantee is re-granted ahead of round-robin. rr is still set to grantee+1. This keeps a multi-byte frame contiguous. A timeout clears the lock hold: the next IDLE uses plain round-robin.
- Undefined: i_lock is ignored and arbitration is pure round-robin.

Test Plan:
- Single requester: i_req=4'b0100 with byte 8'hAB, serializer model raises busy 2 clocks after start for 10 clocks -> ack[2] and start one cycle after req, o_tx_byte=8'hAB, o_grant_idx=2, o_active low 1 clock after busy falls.
- All four request at once with bytes 8'h10, 8'h21, 8'h32, 8'h43 -> acks in order 0,1,2,3; serializer sees 10,21,32,43; no two acks in the same cycle.
- rr fairness: after a grant to 2, requesters 0 and 2 request together -> grant 0 first (rr=3 wraps), then 2.
- Timeout: serializer never raises busy -> o_err_timeout pulses exactly BUSY_TIMEOUT clocks after start, state returns to IDLE, next request is served normally.
- GAP_CLKS=5, two back-to-back requests -> exactly 6 clocks between busy fall and the second o_tx_start; i_rst_n=0 during WAIT_DONE -> all outputs 0 next edge, IDLE, rr=0.
- With UART_TX_ARBITER_LOCK_EN: req0 and req1 both high, i_lock[0]=1 for 3 bytes -> grants 0,0,0 then 1. Without the macro -> grants 0,1,0,1.
